alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Bus-master sequencer that executes one integer ALU operation end to end over the shared 256-bit memory/ALU bus. It takes a start request carrying opcode and three main-memory word indices, then fetches both operands from main memory, loads them into the ALU operand registers, issues the command, waits the ALU latency, reads the result and writes it back to memory. It sits between the test/control master and the `IntegerAlu` / main-memory slaves, replacing hand-sequenced bus traffic.

## Interface
- `DW`, 256: bus data width.
- `MEM_WORDS`, 12: number of main-memory words; valid indices are 0..MEM_WORDS-1 at bus addresses 0x0000 upward.
- `ALU_BASE`, 16'h1000: ALU register base. +0 operand A, +1 operand B, +2 command, +3 result.
- `ALU_LAT`, 2: cycles (>=1) from the command-write cycle to result-readable.

- `Clk`, in, 1: single clock; all logic is on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Start`, in, 1: request; sampled only in IDLE.
- `Opcode`, in, 4: ALU opcode; latched on accept.
- `SrcA`, `SrcB`, `Dst`, in, 4 each: memory word indices; latched on accept.
- `Busy`, out, 1: high in every non-IDLE state.
- `Done`, out, 1: one-cycle completion pulse.
- `Error`, out, 1: one-cycle pulse, coincident with `Done`, for a rejected request.
- `Address`, out, 16: bus address.
- `nRead`, `nWrite`, out, 1 each: active-low bus strobes.
- `DataOut`, out, DW: bus write data.
- `DataIn`, in, DW: bus read data. Valid in the cycle after the `nRead` cycle.

## Operation
- States and order: IDLE, RD_A, CAP_A, WR_A, RD_B, CAP_B, WR_B, WR_CMD, WAIT, RD_R, CAP_R, WR_D, DONE. There is also an ERR state.
- IDLE:
  - If `Start`=1 and SrcA, SrcB and Dst are all < MEM_WORDS, latch the fields and go to RD_A.
  - If `Start`=1 and any index is >= MEM_WORDS, go to ERR.
  - Otherwise stay in IDLE.
- RD_A / RD_B: `nRead`=0, `Address`=SrcA / SrcB.
- CAP_A / CAP_B / CAP_R: bus idle; `DataIn` is captured into the internal A / B / R register at the end of the cycle.
- WR_A: `nWrite`=0, `Address`=ALU_BASE, `DataOut`=A.
- WR_B: `nWrite`=0, `Address`=ALU_BASE+1, `DataOut`=B.
- WR_CMD: `nWrite`=0, `Address`=ALU_BASE+2, `DataOut`=zero-extended Opcode.
- WAIT: stays exactly ALU_LAT cycles, counted by an internal down-counter; bus idle.
- RD_R: `nRead`=0, `Address`=ALU_BASE+3.
- WR_D: `nWrite`=0, `Address`=Dst, `DataOut`=R.
- DONE: `Done`=1, then go to IDLE.
- ERR: `Done`=1 and `Error`=1 for one cycle with no bus access, then go to IDLE.
- Bus idle value: `nRead`=1, `nWrite`=1, `Address`=0, `DataOut`=0.
  - `nRead` and `nWrite` are never both 0.
  - Every strobe lasts exactly one cycle.
- `Start` outside IDLE is ignored and is not queued.
- Input changes after accept have no effect, because all fields are latched.
- SrcA=SrcB is legal (two reads of the same word). Dst equal to a source is legal (the write-back overwrites it).
- All outputs are registered.

## Timing
- Reset values: `Busy`=0, `Done`=0, `Error`=0, `nRead`=1, `nWrite`=1, `Address`=0, `DataOut`=0. State = IDLE; A, B, R and the counter are cleared.
- Cycle numbering: the accept edge is the end of cycle 0. Cycle 1 is RD_A.
  - Strobe cycles: RD_A=1, WR_A=3, RD_B=4, WR_B=6, WR_CMD=7.
  - WAIT occupies cycles 8..7+ALU_LAT.
  - RD_R=8+ALU_LAT, WR_D=10+ALU_LAT, DONE=11+ALU_LAT.
- Latency from accept to `Done` is 11+ALU_LAT cycles; 13 at the default.
- Back-to-back: a new `Start` is accepted in the cycle after DONE, so the minimum request spacing is 12+ALU_LAT cycles.
- Error path: ERR in cycle 1 (`Busy`=1, `Done`=1, `Error`=1); IDLE in cycle 2.
- Reset mid-operation: `Reset`=1 at any edge forces IDLE and reset outputs from the next cycle.
  - Any strobe in progress is dropped.
  - Memory or ALU writes already completed are not undone.
  - No `Done` is produced for the aborted operation.
- `Reset` and `Start` asserted together: reset wins; the request is not accepted.

## Test plan
- Basic add: mem[2]=5, mem[7]=9, Opcode=1, SrcA=2, SrcB=7, Dst=3, with an ALU model that returns A+B after 2 cycles. Required:
  - Bus sequence: read 0x0002, write 0x1000=5, read 0x0007, write 0x1001=9, write 0x1002=1, read 0x1003, write 0x0003=14.
  - `Done` in cycle 13; `Busy` high in cycles 1..13.
- Bad index: SrcB=12 -> no strobes; `Done`=`Error`=1 in cycle 1; `Busy`=0 in cycle 2; memory unchanged.
- Back-to-back with ignored request: second request presented in cycle 14 is accepted, and its RD_A falls in cycle 15. A `Start` held high in cycles 2..12 causes no extra operation.
- Alias: SrcA=SrcB=Dst=4, mem[4]=6, opcode add -> mem[4]=12; address 0x0004 is read twice and written once.
- Reset in cycle 5 (during CAP_B) -> from cycle 6 `Busy`=0, `nRead`=`nWrite`=1, `Address`=0. No `Done`, and no ALU_BASE+1 write occurs.
- ALU_LAT=5 build: `Done` in cycle 16; RD_R in cycle 13.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Bus master that runs one ALU operation end to end:
// fetch A/B from memory, load the ALU, wait, read the result, write it back.
module alu_op_sequencer #(
   parameter int          DW        = 256,
   parameter int          MEM_WORDS = 12,
   parameter logic [15:0] ALU_BASE  = 16'h1000,
   parameter int          ALU_LAT   = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [3:0]    Opcode,
   input  logic [3:0]    SrcA,
   input  logic [3:0]    SrcB,
   input  logic [3:0]    Dst,
   output logic          Busy,
   output logic          Done,
   output logic          Error,
   output logic [15:0]   Address,
   output logic          nRead,
   output logic          nWrite,
   output logic [DW-1:0] DataOut,
   input  logic [DW-1:0] DataIn
);

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_RD_A, S_CAP_A, S_WR_A, S_RD_B, S_CAP_B, S_WR_B,
      S_WR_CMD, S_WAIT, S_RD_R, S_CAP_R, S_WR_D, S_DONE, S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      op_q, op_d;
   logic [3:0]      sa_q, sa_d;
   logic [3:0]      sb_q, sb_d;
   logic [3:0]      dst_q, dst_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [DW-1:0]   r_q, r_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic [15:0]     addr_q, addr_d;
   logic            nread_q, nread_d;
   logic            nwrite_q, nwrite_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            idx_ok;

   assign idx_ok = (32'(SrcA) < 32'(MEM_WORDS)) &&
                   (32'(SrcB) < 32'(MEM_WORDS)) &&
                   (32'(Dst)  < 32'(MEM_WORDS));

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dst_d   = dst_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (idx_ok) begin
                  op_d    = Opcode;
                  sa_d    = SrcA;
                  sb_d    = SrcB;
                  dst_d   = Dst;
                  state_d = S_RD_A;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_RD_A:  state_d = S_CAP_A;
         S_CAP_A: begin
            a_d     = DataIn;
            state_d = S_WR_A;
         end
         S_WR_A:  state_d = S_RD_B;
         S_RD_B:  state_d = S_CAP_B;
         S_CAP_B: begin
            b_d     = DataIn;
            state_d = S_WR_B;
         end
         S_WR_B:  state_d = S_WR_CMD;
         S_WR_CMD: begin
            cnt_d   = CW'(ALU_LAT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_RD_R;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_RD_R:  state_d = S_CAP_R;
         S_CAP_R: begin
            r_d     = DataIn;
            state_d = S_WR_D;
         end
         S_WR_D:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE) || (state_d == S_ERR);
      error_d  = (state_d == S_ERR);
      nread_d  = 1'b1;
      nwrite_d = 1'b1;
      addr_d   = '0;
      dout_d   = '0;
      unique case (state_d)
         S_RD_A: begin
            nread_d = 1'b0;
            addr_d  = 16'(sa_d);
         end
         S_RD_B: begin
            nread_d = 1'b0;
            addr_d  = 16'(sb_d);
         end
         S_WR_A: begin
            nwrite_d = 1'b0;
            addr_d   = ALU_BASE;
            dout_d   = a_d;
         end
         S_WR_B: begin
            nwrite_d = 1'b0;
            addr_d   = ALU_BASE + 16'd1;
            dout_d   = b_d;
         end
         S_WR_CMD: begin
            nwrite_d = 1'b0;
            addr_d   = ALU_BASE + 16'd2;
            dout_d   = DW'(op_d);
         end
         S_RD_R: begin
            nread_d = 1'b0;
            addr_d  = ALU_BASE + 16'd3;
         end
         S_WR_D: begin
            nwrite_d = 1'b0;
            addr_d   = 16'(dst_d);
            dout_d   = r_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         sa_q     <= '0;
         sb_q     <= '0;
         dst_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         addr_q   <= '0;
         nread_q  <= 1'b1;
         nwrite_q <= 1'b1;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dst_q    <= dst_d;
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         addr_q   <= addr_d;
         nread_q  <= nread_d;
         nwrite_q <= nwrite_d;
         dout_q   <= dout_d;
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign Error   = error_q;
   assign Address = addr_q;
   assign nRead   = nread_q;
   assign nWrite  = nwrite_q;
   assign DataOut = dout_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a memory + ALU bus model.
// Second instance covers the long-latency build.
module tb_alu_op_sequencer;

   localparam int DW = 256;
   localparam logic [DW-1:0] JUNK = {8{32'hDEADBEEF}};

   logic          Clk = 1'b0;
   logic          Reset, Start, start5;
   logic [3:0]    Opcode, SrcA, SrcB, Dst;
   logic          Busy, Done, Error, nRead, nWrite;
   logic [15:0]   Address;
   logic [DW-1:0] DataOut, DataIn;
   logic          busy5, done5, error5, nread5, nwrite5;
   logic [15:0]   addr5;
   logic [DW-1:0] dout5, din5;

   always #5 Clk = ~Clk;

   alu_op_sequencer u_dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode),
      .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst), .Busy(Busy), .Done(Done),
      .Error(Error), .Address(Address), .nRead(nRead), .nWrite(nWrite),
      .DataOut(DataOut), .DataIn(DataIn)
   );

   alu_op_sequencer #(.ALU_LAT(5)) u_dut5 (
      .Clk(Clk), .Reset(Reset), .Start(start5), .Opcode(Opcode),
      .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst), .Busy(busy5), .Done(done5),
      .Error(error5), .Address(addr5), .nRead(nread5), .nWrite(nwrite5),
      .DataOut(dout5), .DataIn(din5)
   );

   assign din5 = JUNK;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [319:0] act,
                      input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // memory + ALU slave model
   logic [DW-1:0] mem [12];
   logic [DW-1:0] alu_a, alu_b, alu_r;
   logic          bd_we;
   logic [3:0]    bd_addr;
   logic [DW-1:0] bd_data;

   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
      input logic [DW-1:0] b, input logic [3:0] op);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a ^ b;
         default: return a & b;
      endcase
   endfunction

   always @(posedge Clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (!nWrite) begin
         if (Address < 16'd12) mem[Address[3:0]] <= DataOut;
         else if (Address == 16'h1000) alu_a <= DataOut;
         else if (Address == 16'h1001) alu_b <= DataOut;
         else if (Address == 16'h1002) alu_r <= alu_f(alu_a, alu_b, DataOut[3:0]);
      end
      if (!nRead) begin
         if (Address < 16'd12)         DataIn <= mem[Address[3:0]];
         else if (Address == 16'h1003) DataIn <= alu_r;
         else                          DataIn <= JUNK;
      end else begin
         DataIn <= JUNK;
      end
   end

   typedef struct {
      int            t;
      logic          wr;
      logic [15:0]   addr;
      logic [DW-1:0] data;
   } ev_t;

   ev_t ev[$];
   int  done_t[$];
   int  err_t[$];

   always @(negedge Clk) begin
      if (!nRead || !nWrite)
         ev.push_back('{cyc, !nWrite, Address, nWrite ? {DW{1'b0}} : DataOut});
      if (Done)  done_t.push_back(cyc);
      if (Error) err_t.push_back(cyc);
   end

   typedef struct {
      logic [3:0]    op, sa, sb, dst;
      logic [DW-1:0] va, vb, exp;
      logic          bad;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] op, sa, sb, dst,
      input logic [DW-1:0] va, vb, exp, input logic bad);
      vec_t v;
      v.op = op; v.sa = sa; v.sb = sb; v.dst = dst;
      v.va = va; v.vb = vb; v.exp = exp; v.bad = bad;
      return v;
   endfunction

   task automatic bd_write(input logic [3:0] a, input logic [DW-1:0] d);
      @(negedge Clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge Clk);
      bd_we = 1'b0;
   endtask

   task automatic accept(input logic [3:0] op, sa, sb, dst, output int base);
      @(negedge Clk);
      Start = 1'b1; Opcode = op; SrcA = sa; SrcB = sb; Dst = dst;
      @(posedge Clk);
      #1;
      base  = cyc;
      Start = 1'b0;
   endtask

   function automatic logic [319:0] pk(input int t, input logic wr,
      input logic [15:0] a, input logic [DW-1:0] d);
      return 320'({16'(t), wr, a, d});
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int            base, e0, d0, r0, dcyc, ecyc, dmax, n, nexp, diffs;
      bit            busy_ok;
      logic [DW-1:0] snap [12];
      logic [319:0]  xe [7];
      if (v.sa < 4'd12) bd_write(v.sa, v.va);
      if (v.sb < 4'd12) bd_write(v.sb, v.vb);
      foreach (snap[i]) snap[i] = mem[i];
      e0 = ev.size(); d0 = done_t.size(); r0 = err_t.size();
      accept(v.op, v.sa, v.sb, v.dst, base);
      dmax = v.bad ? 1 : 13;
      busy_ok = 1'b1;
      for (int r = 1; r <= 30; r++) begin
         @(negedge Clk);
         if (Busy !== (r <= dmax)) busy_ok = 1'b0;
      end
      dcyc = (done_t.size() > d0) ? done_t[d0] - base + 1 : -1;
      ecyc = (err_t.size() > r0) ? err_t[r0] - base + 1 : -1;
      chk($sformatf("v%0d_done_cycle", idx), 320'(dcyc), 320'(dmax));
      chk($sformatf("v%0d_done_count", idx), 320'(done_t.size() - d0), 320'd1);
      chk($sformatf("v%0d_error_cycle", idx), 320'(ecyc), 320'(v.bad ? 1 : -1));
      chk($sformatf("v%0d_busy", idx), 320'(busy_ok), 320'd1);
      xe[0] = pk(1, 1'b0, 16'(v.sa), '0);
      xe[1] = pk(3, 1'b1, 16'h1000, v.va);
      xe[2] = pk(4, 1'b0, 16'(v.sb), '0);
      xe[3] = pk(6, 1'b1, 16'h1001, v.vb);
      xe[4] = pk(7, 1'b1, 16'h1002, DW'(v.op));
      xe[5] = pk(10, 1'b0, 16'h1003, '0);
      xe[6] = pk(12, 1'b1, 16'(v.dst), v.exp);
      n    = ev.size() - e0;
      nexp = v.bad ? 0 : 7;
      chk($sformatf("v%0d_bus_count", idx), 320'(n), 320'(nexp));
      for (int i = 0; i < n && i < nexp; i++)
         chk($sformatf("v%0d_bus%0d", idx, i),
             pk(ev[e0+i].t - base + 1, ev[e0+i].wr, ev[e0+i].addr, ev[e0+i].data),
             xe[i]);
      if (!v.bad) begin
         chk($sformatf("v%0d_mem_dst", idx), 320'(mem[v.dst]), 320'(v.exp));
      end else begin
         diffs = 0;
         foreach (snap[i]) if (mem[i] !== snap[i]) diffs++;
         chk($sformatf("v%0d_mem_unchanged", idx), 320'(diffs), 320'd0);
      end
   endtask

   vec_t vt [9];

   initial begin
      int base, e0, d0, n, rdr, d5;
      vt[0] = mk(4'd1, 4'd2, 4'd7, 4'd3, 5, 9, 14, 1'b0);
      vt[1] = mk(4'd2, 4'd0, 4'd11, 4'd11, 100, 30, 70, 1'b0);
      vt[2] = mk(4'd1, 4'd4, 4'd4, 4'd4, 6, 6, 12, 1'b0);
      vt[3] = mk(4'd3, 4'd1, 4'd5, 4'd0, 'hF0F0, 'h0FF0, 'hFF00, 1'b0);
      vt[4] = mk(4'd1, 4'd6, 4'd8, 4'd9, '1, 1, 0, 1'b0);
      vt[5] = mk(4'd4, 4'd10, 4'd9, 4'd10, 'hFF00FF, 'h0F0F0F, 'h0F000F, 1'b0);
      vt[6] = mk(4'd1, 4'd2, 4'd12, 4'd3, 5, 0, 0, 1'b1);
      vt[7] = mk(4'd1, 4'd0, 4'd1, 4'd15, 1, 2, 0, 1'b1);
      vt[8] = mk(4'd2, 4'd12, 4'd3, 4'd3, 0, 7, 0, 1'b1);

      Reset = 1'b1; Start = 1'b0; start5 = 1'b0; bd_we = 1'b0;
      bd_addr = '0; bd_data = '0;
      Opcode = '0; SrcA = '0; SrcB = '0; Dst = '0;
      repeat (3) @(negedge Clk);
      chk("reset_state", 320'({Busy, Done, Error, nRead, nWrite, Address, DataOut}),
          320'({3'b000, 2'b11, 16'h0, {DW{1'b0}}}));
      chk("reset_state5", 320'({busy5, done5, error5, nread5, nwrite5, addr5, dout5}),
          320'({3'b000, 2'b11, 16'h0, {DW{1'b0}}}));
      Reset = 1'b0;
      for (int i = 0; i < 12; i++) bd_write(4'(i), DW'(1000 + i));

      for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

      // back-to-back, with a held Start that must be ignored
      bd_write(4'd2, 5);
      bd_write(4'd7, 9);
      e0 = ev.size(); d0 = done_t.size();
      accept(4'd1, 4'd2, 4'd7, 4'd3, base);
      for (int k = 0; k < 32; k++) begin
         @(negedge Clk);
         if (cyc - base + 1 == 15)
            chk("b2b_rd_a_cycle15", 320'({nRead, Address}), 320'({1'b0, 16'h0007}));
         if (cyc - base + 1 >= 2 && cyc - base + 1 <= 12) begin
            Start = 1'b1; Opcode = 4'd3; SrcA = 4'd9; SrcB = 4'd9; Dst = 4'd9;
         end else if (cyc - base + 1 == 14) begin
            Start = 1'b1; Opcode = 4'd2; SrcA = 4'd7; SrcB = 4'd2; Dst = 4'd5;
         end else begin
            Start = 1'b0;
         end
      end
      n = 0;
      foreach (ev[i]) if (i >= e0 && ev[i].t - base + 1 <= 14) n++;
      chk("b2b_first_op_bus_count", 320'(n), 320'd7);
      chk("b2b_done_count", 320'(done_t.size() - d0), 320'd2);
      if (done_t.size() - d0 >= 2) begin
         chk("b2b_done1_cycle", 320'(done_t[d0] - base + 1), 320'd13);
         chk("b2b_done2_cycle", 320'(done_t[d0+1] - base + 1), 320'd27);
      end
      chk("b2b_mem3", 320'(mem[3]), 320'd14);
      chk("b2b_mem5", 320'(mem[5]), 320'd4);

      // reset during CAP_B
      e0 = ev.size(); d0 = done_t.size();
      accept(4'd1, 4'd2, 4'd7, 4'd8, base);
      for (int k = 0; k < 20; k++) begin
         @(negedge Clk);
         if (cyc - base + 1 == 6) begin
            chk("rst_mid_outputs", 320'({Busy, Done, nRead, nWrite, Address}),
                320'({2'b00, 2'b11, 16'h0}));
            Reset = 1'b0;
         end
         if (cyc - base + 1 == 5) Reset = 1'b1;
      end
      chk("rst_mid_no_done", 320'(done_t.size() - d0), 320'd0);
      n = 0;
      foreach (ev[i]) if (i >= e0 && ev[i].wr && ev[i].addr == 16'h1001) n++;
      chk("rst_mid_no_wr_b", 320'(n), 320'd0);
      chk("rst_mid_bus_count", 320'(ev.size() - e0), 320'd3);

      // Reset and Start together: reset wins
      e0 = ev.size();
      @(negedge Clk);
      Reset = 1'b1; Start = 1'b1;
      Opcode = 4'd1; SrcA = 4'd1; SrcB = 4'd2; Dst = 4'd3;
      @(negedge Clk);
      Reset = 1'b0; Start = 1'b0;
      @(negedge Clk);
      chk("rst_start_idle", 320'({Busy, nRead, nWrite}), 320'({1'b0, 2'b11}));
      @(negedge Clk);
      chk("rst_start_no_bus", 320'(ev.size() - e0), 320'd0);

      // long-latency build
      @(negedge Clk);
      start5 = 1'b1; Opcode = 4'd1; SrcA = 4'd2; SrcB = 4'd7; Dst = 4'd3;
      @(posedge Clk);
      #1;
      base = cyc; start5 = 1'b0;
      rdr = -1; d5 = -1;
      for (int k = 0; k < 25; k++) begin
         @(negedge Clk);
         if (!nread5 && addr5 == 16'h1003 && rdr < 0) rdr = cyc - base + 1;
         if (done5 && d5 < 0) d5 = cyc - base + 1;
      end
      chk("lat5_rd_r_cycle", 320'(rdr), 320'd13);
      chk("lat5_done_cycle", 320'(d5), 320'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
